mmio_burst_master: RTL and testbench
====================================

MMIO_BURST_MASTER -- requirements
Module: mmio_burst_master

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, giving the width of the burst-length field; bursts SHALL be 1..2^LEN_W beats.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted this cycle when high together with cmd_valid.
REQ-006 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  input  32  byte address of the first beat.
REQ-008 cmd_len  input  LEN_W  beat count minus one.
REQ-009 wr_valid  input  1  write-data beat offered.
REQ-010 wr_ready  output  1  write-data beat accepted when high together with wr_valid.
REQ-011 wr_data  input  32  write-data beat.
REQ-012 rsp_valid  output  1  read-data beat available.
REQ-013 rsp_ready  input  1  sink accepts the read-data beat.
REQ-014 rsp_data  output  32  read-data beat.
REQ-015 rsp_last  output  1  final beat of the read burst.
REQ-016 bus_we  output  1  SoC bus write strobe, one word per cycle.
REQ-017 bus_a  output  32  SoC bus byte address.
REQ-018 bus_wd  output  32  SoC bus write data.
REQ-019 bus_rd  input  32  SoC bus read data, combinationally valid in the same cycle as bus_a.
REQ-020 busy  output  1  high whenever the state is not IDLE.
REQ-021 err  output  1  one-cycle pulse on rejection of a misaligned command.

Function
REQ-022 The FSM SHALL have states IDLE, WR, RD, RSP.
REQ-023 IDLE: cmd_ready SHALL be 1; cmd_ready SHALL be 0 in every other state.
REQ-024 On a cmd_valid&cmd_ready handshake, the block SHALL latch the address (addr_q), the remaining-beat count (cnt_q = cmd_len) and the direction.
REQ-025 If cmd_addr[1:0] != 0 at the handshake, the command SHALL be consumed; err SHALL be 1 in the next cycle only; the state SHALL remain IDLE; no bus access SHALL occur.
REQ-026 For an aligned command, the next state SHALL be WR if cmd_write=1, else RD.
REQ-027 WR: bus_a=addr_q, bus_wd=wr_data, wr_ready=1, and bus_we=wr_valid (combinational).
REQ-028 WR with wr_valid=0 SHALL stall with bus_we=0 and no state change.
REQ-029 WR on each accepted beat: addr_q += 4; if cnt_q=0 the next state is IDLE, else cnt_q -= 1.
REQ-030 WR throughput SHALL be one beat per cycle when wr_valid is held high.
REQ-031 RD: bus_we=0 and bus_a=addr_q; at the clock edge, bus_rd SHALL be registered into rsp_data, rsp_last SHALL be registered as (cnt_q==0), and the next state SHALL be RSP.
REQ-032 RSP: rsp_valid SHALL be 1; rsp_data and rsp_last SHALL be held stable, and bus_we SHALL stay 0, until rsp_ready=1.
REQ-033 On the RSP handshake: if rsp_last, go to IDLE; else addr_q += 4, cnt_q -= 1, go to RD.
REQ-034 Read latency SHALL be 1 cycle from entering RD to rsp_valid; read throughput SHALL be at most one beat per 2 cycles.
REQ-035 Outside WR, wr_ready SHALL be 0.
REQ-036 Outside WR and RD, bus_a SHALL be 0.
REQ-037 Outside WR, bus_we SHALL be 0.
REQ-038 Outside WR, bus_wd SHALL be 0.
REQ-039 addr_q increments SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000) without error.
REQ-040 In WR and RSP, a cmd_valid SHALL be ignored (not consumed) until the state returns to IDLE.
REQ-041 busy SHALL be registered-state-derived and free of glitches relative to the state.

Reset
REQ-042 rst=0 SHALL immediately force the state to IDLE, including mid-burst, and abandon any burst in progress without a response.
REQ-043 rst=0 SHALL immediately clear addr_q, cnt_q, rsp_data, rsp_last, rsp_valid, bus_we, bus_a, bus_wd, wr_ready, busy and err to 0.
REQ-044 cmd_ready SHALL be 1 while rst=0 and after reset release.
REQ-045 The first handshake SHALL be possible on the first rising edge with rst=1.

Verification
REQ-046 Write burst: cmd write, addr 0x00000010, len 3, wr_data 0xA0..0xA3 held valid -> bus_we high 4 consecutive cycles at 0x10, 0x14, 0x18, 0x1C; busy drops the next cycle.
REQ-047 Read burst with memory model bus_rd = a+0x100, addr 0x20, len 1, rsp_ready=1 -> rsp_data 0x120 then 0x124; rsp_last only on 0x124; bus_we never 1.
REQ-048 Backpressure: rsp_ready low 5 cycles during a read -> rsp_valid/rsp_data stable; bus_a stays 0; no skipped or repeated beats.
REQ-049 Misaligned: addr 0x00000006 -> err=1 for exactly one cycle; bus_we stays 0; cmd_ready stays 1.
REQ-050 Wrap: write addr 0xFFFFFFFC, len 1 -> bus_a 0xFFFFFFFC then 0x00000000.
REQ-051 Reset mid-burst: assert rst=0 during beat 2 of a len-7 write -> all outputs 0 immediately; after release a new read command completes normally.

Source files
------------

// File: rtl/mmio_burst_master.sv
// Burst master that turns write/read burst commands into single-word SoC bus accesses.
// Writes stream one beat per cycle; reads return one registered beat per RD/RSP pair.
module mmio_burst_master #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_last,
    output logic             bus_we,
    output logic [31:0]      bus_a,
    output logic [31:0]      bus_wd,
    input  logic [31:0]      bus_rd,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_last;
    logic             r_err;

    logic w_in_idle;
    logic w_in_wr;
    logic w_in_rd;
    logic w_in_rsp;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_wr   = (r_state == S_WR);
    assign w_in_rd   = (r_state == S_RD);
    assign w_in_rsp  = (r_state == S_RSP);

    // Bus-facing outputs decode only the registered state, so reset zeroes them at once.
    assign cmd_ready = w_in_idle;
    assign wr_ready  = w_in_wr;
    assign bus_we    = w_in_wr & wr_valid;
    assign bus_a     = (w_in_wr | w_in_rd) ? r_addr : 32'd0;
    assign bus_wd    = w_in_wr ? wr_data : 32'd0;
    assign rsp_valid = w_in_rsp;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign busy      = ~w_in_idle;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_cnt      <= '0;
            r_rsp_data <= 32'd0;
            r_rsp_last <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_cnt  <= cmd_len;
                        // A misaligned command is swallowed and only flagged.
                        if (cmd_addr[1:0] != 2'b00) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= cmd_write ? S_WR : S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (wr_valid) begin
                        r_addr <= r_addr + 32'd4;
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_rsp_data <= bus_rd;
                    r_rsp_last <= (r_cnt == '0);
                    r_state    <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        if (r_rsp_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr  <= r_addr + 32'd4;
                            r_cnt   <= r_cnt - 1'b1;
                            r_state <= S_RD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_burst_master.sv
// Bench for mmio_burst_master: directed bursts plus random traffic checked against
// an address/beat model (beat i lives at base+4*i, memory returns address+0x100).
`timescale 1ns/1ps
module tb_mmio_burst_master;

    localparam int LEN_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_last;
    logic             bus_we;
    logic [31:0]      bus_a;
    logic [31:0]      bus_wd;
    logic [31:0]      bus_rd;
    logic             busy;
    logic             err;

    int n_assert;
    int n_fail;

    mmio_burst_master #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .bus_we(bus_we), .bus_a(bus_a), .bus_wd(bus_wd), .bus_rd(bus_rd),
        .busy(busy), .err(err)
    );

    // Memory model: every word reads back as its own address plus 0x100.
    assign bus_rd = bus_a + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
        chk({tag, "_bus_we"},    32'(bus_we),    32'd0);
        chk({tag, "_bus_a"},     bus_a,          32'd0);
        chk({tag, "_bus_wd"},    bus_wd,         32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] base, input int len, input int stall_pct,
                            input bit rnd_data, input logic [31:0] d0);
        int          i;
        int          guard;
        logic        wv;
        logic [31:0] wd;
        logic [31:0] ea;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = base; cmd_len = LEN_W'(len);
        #1;
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        i = 0;
        guard = 0;
        while (i <= len && guard < 400) begin
            guard++;
            wv = ($urandom_range(99) >= stall_pct);
            wd = rnd_data ? $urandom : d0 + 32'(i);
            ea = base + 32'(4 * i);
            wr_valid = wv; wr_data = wd;
            cmd_valid = 1'($urandom_range(1)); cmd_addr = $urandom;
            #1;
            chk("wr_wr_ready", 32'(wr_ready), 32'd1);
            chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("wr_busy", 32'(busy), 32'd1);
            chk("wr_bus_we", 32'(bus_we), 32'(wv));
            chk("wr_bus_a", bus_a, ea);
            chk("wr_bus_wd", bus_wd, wd);
            if (wv) i++;
            tick();
        end
        chk("wr_beats_done", 32'(i), 32'(len + 1));
        wr_valid = 1'b0; cmd_valid = 1'b0;
        #1;
        chk_idle_outputs("wr_end");
    endtask

    task automatic do_read(input logic [31:0] base, input int len, input int stall_fixed);
        int          stalls;
        logic [31:0] ea;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = base; cmd_len = LEN_W'(len);
        #1;
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            ea = base + 32'(4 * i);
            rsp_ready = 1'($urandom_range(1));
            cmd_valid = 1'($urandom_range(1)); cmd_addr = $urandom;
            #1;
            chk("rd_bus_a", bus_a, ea);
            chk("rd_bus_we", 32'(bus_we), 32'd0);
            chk("rd_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rd_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("rd_busy", 32'(busy), 32'd1);
            tick();
            stalls = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(3));
            for (int s = 0; s <= stalls; s++) begin
                rsp_ready = (s == stalls);
                #1;
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_data", rsp_data, ea + 32'h100);
                chk("rsp_last", 32'(rsp_last), 32'(i == len));
                chk("rsp_bus_a", bus_a, 32'd0);
                chk("rsp_bus_we", 32'(bus_we), 32'd0);
                chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
                tick();
            end
        end
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        #1;
        chk_idle_outputs("rd_end");
    endtask

    task automatic do_misaligned(input logic [31:0] a);
        cmd_valid = 1'b1; cmd_write = 1'($urandom_range(1)); cmd_addr = a;
        cmd_len = LEN_W'($urandom_range(15));
        #1;
        chk("mis_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("mis_err_pulse", 32'(err), 32'd1);
        chk_idle_outputs("mis_after");
        tick();
        chk("mis_err_clear", 32'(err), 32'd0);
        chk("mis_bus_we", 32'(bus_we), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = 32'd0; rsp_ready = 1'b0;
        #3;
        chk_idle_outputs("reset");
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_last", 32'(rsp_last), 32'd0);
        tick();
        rst = 1'b1;

        // Directed write burst at 0x10, data 0xA0..0xA3, no stalls.
        do_write(32'h10, 3, 0, 1'b0, 32'hA0);
        // Directed read burst at 0x20, two beats, sink always ready.
        do_read(32'h20, 1, 0);
        // Read with five cycles of sink backpressure on every beat.
        do_read(32'h200, 2, 5);
        do_misaligned(32'h6);
        // Address wrap across the top of the 32-bit space.
        do_write(32'hFFFF_FFFC, 1, 0, 1'b0, 32'h55);
        do_read(32'hFFFF_FFF8, 3, -1);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(4))
                0, 1: do_write($urandom & 32'hFFFF_FFFC, int'($urandom_range(15)), 30, 1'b1, 32'd0);
                2, 3: do_read($urandom & 32'hFFFF_FFFC, int'($urandom_range(15)), -1);
                default: do_misaligned(($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(2)));
            endcase
        end

        // Reset asserted during beat 2 of an 8-beat write.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_len = LEN_W'(7);
        tick();
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'h1111;
        tick();
        wr_data = 32'h2222;
        #1;
        chk("mid_bus_a_beat2", bus_a, 32'h44);
        rst = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_rsp_data", rsp_data, 32'd0);
        chk("rst_mid_rsp_last", 32'(rsp_last), 32'd0);
        tick();
        wr_valid = 1'b0;
        rst = 1'b1;
        do_read(32'h80, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
